// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: parses header/payload frames from a first-word fall-through rx FIFO
module rx_frame_decoder #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_rdata,
    input  logic        rx_rempty,
    output logic        rx_rinc,
    output logic [5:0]  cmd,
    output logic [15:0] arg,
    output logic [1:0]  arg_len,
    output logic        valid,
    input  logic        accept,
    output logic        err_timeout,
    output logic        err_len
);
    typedef enum logic [1:0] {IDLE, MSB, LSB, OUT} state_t;
    state_t      state, state_nx;
    logic [15:0] tcnt, tcnt_nx;
    logic [5:0]  cmd_nx;
    logic [15:0] arg_nx;
    logic [1:0]  len_nx;
    logic        valid_nx, err_to_nx, err_len_nx;
    logic        waiting, expire;
    assign waiting = (state == MSB) || (state == LSB);
    assign expire  = waiting && rx_rempty && (tcnt == TIMEOUT_CYCLES - 16'd1);
    // next-state, byte capture, timeout counting and registered output values
    always_comb begin
        state_nx   = state;
        cmd_nx     = cmd;
        arg_nx     = arg;
        len_nx     = arg_len;
        valid_nx   = 1'b0;
        err_to_nx  = 1'b0;
        err_len_nx = 1'b0;
        rx_rinc    = rst_n && !rx_rempty && (state != OUT);
        tcnt_nx    = (waiting && rx_rempty && !expire) ? ((tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1) : 16'd0;
        case (state)
            IDLE: begin
                if (rx_rinc) begin
                    if (rx_rdata[7:6] == 2'd3) begin
                        err_len_nx = 1'b1;
                    end else begin
                        cmd_nx   = rx_rdata[5:0];
                        len_nx   = rx_rdata[7:6];
                        arg_nx   = 16'h0000;
                        state_nx = (rx_rdata[7:6] == 2'd0) ? OUT : MSB;
                    end
                end
            end
            MSB: begin
                if (rx_rinc) begin
                    arg_nx   = {rx_rdata, 8'h00};
                    state_nx = (arg_len == 2'd1) ? OUT : LSB;
                end else if (expire) begin
                    err_to_nx = 1'b1;
                    state_nx  = IDLE;
                end
            end
            LSB: begin
                if (rx_rinc) begin
                    arg_nx[7:0] = rx_rdata;
                    state_nx    = OUT;
                end else if (expire) begin
                    err_to_nx = 1'b1;
                    state_nx  = IDLE;
                end
            end
            OUT: begin
                if (valid && accept) state_nx = IDLE;
                else valid_nx = 1'b1;
            end
        endcase
    end
    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tcnt        <= 16'd0;
            cmd         <= 6'd0;
            arg         <= 16'd0;
            arg_len     <= 2'd0;
            valid       <= 1'b0;
            err_timeout <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            cmd         <= cmd_nx;
            arg         <= arg_nx;
            arg_len     <= len_nx;
            valid       <= valid_nx;
            err_timeout <= err_to_nx;
            err_len     <= err_len_nx;
        end
    end
endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb_rx_frame_decoder: FIFO-fed randomized and directed checks against a byte-stream frame model
module tb_rx_frame_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_rdata = 8'h00;
    logic        rx_rempty = 1'b1;
    logic        rx_rinc;
    logic [5:0]  cmd;
    logic [15:0] arg;
    logic [1:0]  arg_len;
    logic        valid;
    logic        accept = 1'b0;
    logic        err_timeout;
    logic        err_len;

    rx_frame_decoder #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdata(rx_rdata), .rx_rempty(rx_rempty),
        .rx_rinc(rx_rinc), .cmd(cmd), .arg(arg), .arg_len(arg_len), .valid(valid),
        .accept(accept), .err_timeout(err_timeout), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rinc_cnt = 0;
    int exp_errlen = 0;
    int exp_to = 0;
    logic [7:0]  fifo[$];
    logic [7:0]  src[$];
    logic [23:0] exp_q[$];
    logic        p_active = 1'b0;
    logic [5:0]  p_cmd;
    logic [1:0]  p_len;
    logic [15:0] p_arg;
    int          p_got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // frame model: parse the byte stream as written into the FIFO
    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        if (!p_active) begin
            if (b[7:6] == 2'd3) exp_errlen++;
            else if (b[7:6] == 2'd0) exp_q.push_back({b[5:0], 16'h0000, 2'd0});
            else begin
                p_active = 1'b1;
                p_cmd = b[5:0];
                p_len = b[7:6];
                p_arg = 16'h0000;
                p_got = 0;
            end
        end else begin
            if (p_got == 0) p_arg[15:8] = b;
            else p_arg[7:0] = b;
            p_got++;
            if (p_got == int'(p_len)) begin
                exp_q.push_back({p_cmd, p_arg, p_len});
                p_active = 1'b0;
            end
        end
    endtask

    task automatic model_abort();
        p_active = 1'b0;
    endtask

    task automatic step();
        logic took;
        @(negedge clk);
        rx_rempty = (fifo.size() == 0);
        rx_rdata = rx_rempty ? 8'h00 : fifo[0];
        #1 took = rx_rinc;
        @(posedge clk);
        #1;
        if (took && fifo.size() > 0) begin
            void'(fifo.pop_front());
            rinc_cnt++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        #2;
        chk("rinc_rule", rx_rinc & (rx_rempty | valid | ~rst_n), 0);
        chk("err_excl", err_len & err_timeout, 0);
        if (valid) begin
            chk("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("frame", {cmd, arg, arg_len}, exp_q[0]);
                if (accept) void'(exp_q.pop_front());
            end
        end
        if (err_len) begin
            chk("err_len_expected", exp_errlen > 0, 1);
            if (exp_errlen > 0) exp_errlen--;
        end
        if (err_timeout) begin
            chk("err_timeout_expected", exp_to > 0, 1);
            if (exp_to > 0) exp_to--;
        end
    end

    initial begin
        int idle_run;
        int guard;
        logic [7:0] h;
        run(2);
        chk("reset_outs", {cmd, arg, arg_len, valid, err_timeout, err_len}, 0);
        rst_n = 1'b1;
        run(2);
        chk("idle_outs", {valid, err_timeout, err_len}, 0);

        // L=2 frame, accept high: valid on 4th edge for exactly one cycle, 3 reads
        accept = 1'b1;
        rinc_cnt = 0;
        push(8'h85); push(8'h12); push(8'h34);
        chk("model_85", exp_q[0], {6'h05, 16'h1234, 2'd2});
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("lat_l2_valid", valid, k == 4);
        end
        chk("rinc_cnt_l2", rinc_cnt, 3);

        // L=0 frame held with accept low; queued byte must not be read
        accept = 1'b0;
        rinc_cnt = 0;
        push(8'h07); push(8'h85);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("hold_l0_valid", valid, k >= 2);
        end
        chk("hold_l0_outs", {cmd, arg, arg_len}, {6'h07, 16'h0000, 2'd0});
        chk("hold_l0_rinc", rinc_cnt, 1);
        accept = 1'b1;
        push(8'h12); push(8'h34);
        run(10);

        // timeout after 8 empty cycles in MSB
        exp_to = 1;
        push(8'h41);
        model_abort();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("timeout_pulse", err_timeout, k == 9);
            chk("timeout_novalid", valid, 0);
        end
        push(8'h47); push(8'h99);
        chk("model_47", exp_q[0], {6'h07, 16'h9900, 2'd1});
        run(8);

        // reserved length code drops the header; following bytes resync
        push(8'hC3); push(8'h42); push(8'hAB); push(8'hCD);
        chk("model_42", exp_q[0], {6'h02, 16'hAB00, 2'd1});
        chk("model_errlen", exp_errlen, 2);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("errlen_pulse", err_len, (k == 1) || (k == 6));
            chk("errlen_valid", valid, k == 4);
        end
        run(3);

        // reset in LSB state discards the partial frame
        push(8'h9F); push(8'h55);
        run(2);
        rst_n = 1'b0;
        model_abort();
        push(8'h01);
        step();
        chk("midreset_outs", {cmd, arg, arg_len, valid, err_timeout, err_len}, 0);
        chk("midreset_fifo", fifo.size(), 1);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("post_reset_valid", valid, k == 2);
        end
        chk("post_reset_cmd", {cmd, arg_len}, {6'h01, 2'd0});

        // randomized stream with bounded gaps and random back-pressure
        for (int f = 0; f < 250; f++) begin
            h = 8'($urandom);
            src.push_back(h);
            if (h[7:6] != 2'd3)
                for (int j = 0; j < int'(h[7:6]); j++) src.push_back(8'($urandom));
        end
        idle_run = 0;
        while (src.size() > 0) begin
            accept = ($urandom_range(0, 3) != 0);
            if (idle_run >= 3 || $urandom_range(0, 1) == 1) begin
                push(src.pop_front());
                idle_run = 0;
            end else idle_run++;
            step();
        end
        accept = 1'b1;
        guard = 0;
        while ((fifo.size() > 0 || exp_q.size() > 0 || valid) && guard < 300) begin
            step();
            guard++;
        end
        run(3);
        chk("drain", exp_q.size() + fifo.size(), 0);
        chk("errlen_pending", exp_errlen, 0);
        chk("timeout_pending", exp_to, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
